// File: rtl/approx_serial_adder_ctrl.sv
// approx_serial_adder_ctrl: bit-serial adder, one bit per cycle, LSB first.
// The lowest K positions use an approximate OR/AND cell and the rest use exact full adders.
`default_nettype none

module approx_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       approx_bits,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam int            IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int            KMAX     = (WIDTH - 1 > 31) ? 31 : WIDTH - 1;
  localparam logic [4:0]    KMAX_V   = KMAX[4:0];
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [4:0]       k_q, k_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic [15:0]      cnt_q, cnt_d;

  logic w_x, w_y, w_z, w_approx, w_s, w_c;

  assign w_x      = a_q[idx_q];
  assign w_y      = b_q[idx_q];
  assign w_z      = carry_q;
  assign w_approx = ({27'd0, k_q} > 32'(idx_q));
  assign w_s      = w_approx ? (w_x | w_y | w_z) : (w_x ^ w_y ^ w_z);
  assign w_c      = w_approx ? (w_x & w_y)
                             : ((w_x & w_y) | (w_x & w_z) | (w_y & w_z));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    work_d  = work_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          k_d     = (approx_bits > KMAX_V) ? KMAX_V : approx_bits;
          carry_d = 1'b0;
          idx_d   = '0;
          work_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          // Partial bits live in work_q so out_sum keeps the previous result until completion.
          work_d[idx_q] = w_s;
          carry_d       = w_c;
          idx_d         = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            sum_d   = {w_c, work_d};
            carry_d = 1'b0;
            idx_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  assign out_sum   = sum_q;
  assign op_count  = cnt_q;

endmodule

`default_nettype wire

// File: doc/approx_serial_adder_ctrl.md
APPROX_SERIAL_ADDER_CTRL -- requirements
Module: approx_serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts an operand pair.
REQ-006 SHALL have ports in_a and in_b, input, WIDTH bits each: the operands.
REQ-007 SHALL have port approx_bits, input, 5 bits: K, the number of LSB positions that use the approximate cell.
REQ-008 SHALL have port abort, input, 1 bit: synchronous cancel of the operation in flight.
REQ-009 SHALL have port out_valid, output, 1 bit: the result is available.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port out_sum, output, WIDTH+1 bits: the result.
REQ-012 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-013 SHALL have port op_count, output, 16 bits: count of completed operations, saturating.

Function
REQ-014 SHALL implement a bit-serial ripple adder that processes one bit position per cycle, LSB first.
REQ-015 SHALL compute bit i (i < K_eff) with the approximate cell: S = X|Y|Z, Cout = X&Y.
REQ-016 SHALL compute bit i (i >= K_eff) with an exact full adder: S = X^Y^Z, Cout = majority(X,Y,Z).
REQ-017 SHALL set K_eff = min(approx_bits, WIDTH-1), so the MSB position is always exact.
REQ-018 SHALL sample approx_bits only at accept; later changes to approx_bits SHALL NOT affect the operation in flight.
REQ-019 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-020 In IDLE: in_ready=1, out_valid=0.
REQ-021 On in_valid&in_ready: capture in_a, in_b and K_eff; set carry=0 and bit index=0; go to RUN.
REQ-022 In RUN: in_ready=0; each cycle compute bit[index], write it into the sum register, update carry, increment index.
REQ-023 In RUN, when index=WIDTH-1 is processed: set out_sum[WIDTH] = final carry and go to DONE.
REQ-024 Latency: out_valid SHALL rise WIDTH cycles after the accept edge (16 for the default).
REQ-025 In DONE: out_valid=1 and out_sum held stable until out_ready=1.
REQ-026 In DONE with out_ready=1: increment op_count, saturating at 0xFFFF, and go to IDLE.
REQ-027 No same-cycle re-accept: in_ready SHALL return to 1 the cycle after handoff; peak throughput is one operation per WIDTH+2 cycles.
REQ-028 in_valid SHALL be ignored outside IDLE.
REQ-029 abort=1 in RUN: go to IDLE next edge, no out_valid, op_count unchanged, partial sum discarded.
REQ-030 abort SHALL be ignored in IDLE and DONE.
REQ-031 out_sum SHALL be undefined-free: it holds the last completed result (or 0) whenever out_valid=0.

Reset
REQ-032 rst_n low SHALL asynchronously force state=IDLE, out_sum=0, op_count=0, carry=0, index=0, out_valid=0, busy=0; in_ready SHALL be 1 after release.
REQ-033 Reset during RUN or DONE SHALL discard the operation with no output produced.
REQ-034 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-035 K=0, A=0xFFFF, B=0x0001 -> out_valid 16 cycles after accept, out_sum=0x10000, op_count=1.
REQ-036 K=15, A=0x0001, B=0x0001 -> out_sum=0x00003 (approximate), differing from the exact result 0x00002.
REQ-037 K=20 (clamped to 15), A=0x8000, B=0x8000 -> out_sum=0x10000; A=0xFFFF, B=0x0000 -> out_sum=0x0FFFF.
REQ-038 out_ready held low for 10 cycles in DONE, with in_valid=1 and new operands -> out_sum stable, in_ready=0, no accept; release -> IDLE, next accept one cycle later.
REQ-039 abort at the 5th RUN cycle -> IDLE next cycle, out_valid never rises, op_count unchanged; the following operation A=3, B=5, K=0 -> out_sum=0x00008.
REQ-040 rst_n pulsed low mid-RUN -> all outputs at reset values immediately (asynchronously); a fresh operation after release completes correctly.
